pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core with precise exceptions. It replaces the per-stage hand-written registers (D→E, E→M, M→W) with one generic block. The block carries an opaque payload plus the exception-critical sideband: PC, branch-delay flag, exception code and valid. It adds a freeze (hold) mode and optional bubble/flush statistics.

## Interface
- PAYLOAD_W, 160, width of opaque payload (instr, operands, register addresses, immediates)
- PC_RESET, 32'h0000_3000, out_pc value after reset
- HANDLER_PC, 32'h0000_4180, out_pc value loaded on flush
- CNT_W, 16, width of hold_cycles and statistics counters
- clk  in  1  sole clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; asserting (0) clears all state immediately
- flush  in  1  exception/eret request; highest-priority functional command
- freeze  in  1  hold current contents (a later stage is stalled)
- bubble  in  1  insert NOP, preserving PC/BD (this stage's producer is stalled by hazard)
- in_valid  in  1  upstream slot holds a real instruction
- in_payload  in  PAYLOAD_W  upstream payload
- in_pc  in  32  upstream PC
- in_bd  in  1  upstream instruction is in a branch delay slot
- in_exc  in  5  upstream exception code (0 = none)
- out_valid  out  1  registered
- out_payload  out  PAYLOAD_W  registered
- out_pc  out  32  registered
- out_bd  out  1  registered
- out_exc  out  5  registered
- hold_cycles  out  CNT_W  consecutive cycles current contents have been frozen, saturating
- bubble_cnt, flush_cnt  out  CNT_W each  present only with PIPE_STAGE_STATS_EN

## Operation
- Command priority, evaluated each rising edge: flush > freeze > bubble > load.
- Reset (async, reset=0): out_valid=0, out_payload=0, out_pc=PC_RESET, out_bd=0, out_exc=0, hold_cycles=0, statistics counters=0.
- FLUSH: out_valid=0, out_payload=0, out_exc=0, out_bd=0, out_pc=HANDLER_PC; hold_cycles=0.
- FREEZE: all outputs keep their values; hold_cycles increments and saturates at 2^CNT_W−1.
- BUBBLE: out_valid=0, out_payload=0, out_exc=0, out_pc=in_pc, out_bd=in_bd; hold_cycles=0. This keeps the EPC and BD of the stalled instruction for an interrupt taken on the bubble.
- LOAD: all out_* take the corresponding in_*; hold_cycles=0.
- in_valid=0 under LOAD propagates as-is. The payload is not forced to zero.
- Internal state (one register set, no FIFO): the mode decode is a pure function of the commands. hold_cycles is the only cross-cycle state beyond the data registers.
- freeze and bubble together: freeze wins and contents are held.

## Timing
- Latency 1 cycle in → out under LOAD. No combinational path from any input to any output.
- Commands are sampled only at the rising edge. Glitches between edges are ignored.
- Reset deassertion is synchronised externally. The first edge with reset=1 is a normal command edge.
- Reset asserted mid-freeze: counters and outputs clear at once. The next non-reset edge follows normal priority.
- hold_cycles at max stays at max while freeze persists. Any non-freeze edge returns it to 0.

## Configuration
- PIPE_STAGE_STATS_EN defined: bubble_cnt increments on each BUBBLE edge and flush_cnt on each FLUSH edge. Both wrap modulo 2^CNT_W and clear on reset. A frozen edge counts neither.
- Undefined: the ports and their counters are absent. All other behaviour is identical.

## Structure
- Shared package pipe_pkg: HANDLER_PC and PC_RESET defaults, EXC_NONE=5'd0, and the 2-bit stage-command enum (CMD_LOAD, CMD_BUBBLE, CMD_FREEZE, CMD_FLUSH).
- One sub-module, pipe_stage_cmd: a priority encoder mapping {flush, freeze, bubble} to the command enum. The datapath registers stay in pipe_stage_reg.

## Test plan
- Reset: drive reset=0 with random inputs → out_pc=32'h0000_3000, out_valid=0, out_payload=0, hold_cycles=0, with no clock edge needed.
- Load: in_pc=32'h0000_3010, in_bd=1, in_exc=5'd4, in_valid=1, payload=0xA5.. → next edge outputs match exactly.
- Bubble: in_pc=32'h0000_3020, in_bd=1, bubble=1 → out_pc=32'h0000_3020, out_bd=1, out_valid=0, out_payload=0, out_exc=0.
- Flush priority: flush=freeze=bubble=1 → out_pc=32'h0000_4180, out_bd=0, out_valid=0. With stats: flush_cnt 0→1, bubble_cnt unchanged.
- Freeze: load pc 32'h0000_3030, then freeze for 5 edges with changing inputs → outputs constant, hold_cycles=5. With CNT_W=2, hold_cycles saturates at 3.
- Async reset mid-freeze: hold_cycles=3, pull reset low between edges → outputs return to reset values immediately.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register:
// reset/handler PC defaults, the "no exception" code and the stage-command encoding.
package pipe_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;
  localparam logic [4:0]  EXC_NONE           = 5'd0;

  typedef enum logic [1:0] {
    CMD_LOAD   = 2'd0,
    CMD_BUBBLE = 2'd1,
    CMD_FREEZE = 2'd2,
    CMD_FLUSH  = 2'd3
  } stage_cmd_e;

endpackage

// File: rtl/pipe_stage_cmd.sv
// Priority encoder turning the raw stage controls into a single command:
// flush > freeze > bubble > load.
module pipe_stage_cmd
  import pipe_pkg::*;
(
  input  logic       flush,
  input  logic       freeze,
  input  logic       bubble,
  output logic [1:0] cmd
);

  always_comb begin
    cmd = CMD_LOAD;
    if (flush)       cmd = CMD_FLUSH;
    else if (freeze) cmd = CMD_FREEZE;
    else if (bubble) cmd = CMD_BUBBLE;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register carrying payload plus PC/BD/exception sideband,
// with freeze, bubble and flush. Define PIPE_STAGE_STATS_EN for bubble/flush counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          PAYLOAD_W  = 160,
  parameter logic [31:0] PC_RESET   = PC_RESET_DEFAULT,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT,
  parameter int          CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 freeze,
  input  logic                 bubble,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [31:0]          in_pc,
  input  logic                 in_bd,
  input  logic [4:0]           in_exc,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [31:0]          out_pc,
  output logic                 out_bd,
  output logic [4:0]           out_exc,
`ifdef PIPE_STAGE_STATS_EN
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
`endif
  output logic [CNT_W-1:0]     hold_cycles
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [1:0]           cmd_p0;
  logic                 valid_p1;
  logic [PAYLOAD_W-1:0] payload_p1;
  logic [31:0]          pc_p1;
  logic                 bd_p1;
  logic [4:0]           exc_p1;
  logic [CNT_W-1:0]     hold_p1;

  pipe_stage_cmd u_cmd (
    .flush  (flush),
    .freeze (freeze),
    .bubble (bubble),
    .cmd    (cmd_p0)
  );

  // p0 -> p1: command applied to the register set at the rising edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_p1   <= 1'b0;
      payload_p1 <= '0;
      pc_p1      <= PC_RESET;
      bd_p1      <= 1'b0;
      exc_p1     <= EXC_NONE;
      hold_p1    <= '0;
    end else begin
      case (cmd_p0)
        CMD_FLUSH: begin
          valid_p1   <= 1'b0;
          payload_p1 <= '0;
          pc_p1      <= HANDLER_PC;
          bd_p1      <= 1'b0;
          exc_p1     <= EXC_NONE;
          hold_p1    <= '0;
        end
        CMD_FREEZE: begin
          hold_p1    <= sat_inc(hold_p1);
        end
        // PC/BD survive the bubble so an interrupt taken here reports the stalled instruction
        CMD_BUBBLE: begin
          valid_p1   <= 1'b0;
          payload_p1 <= '0;
          pc_p1      <= in_pc;
          bd_p1      <= in_bd;
          exc_p1     <= EXC_NONE;
          hold_p1    <= '0;
        end
        default: begin
          valid_p1   <= in_valid;
          payload_p1 <= in_payload;
          pc_p1      <= in_pc;
          bd_p1      <= in_bd;
          exc_p1     <= in_exc;
          hold_p1    <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] bubble_cnt_p1;
  logic [CNT_W-1:0] flush_cnt_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt_p1 <= '0;
      flush_cnt_p1  <= '0;
    end else begin
      if (cmd_p0 == CMD_BUBBLE) bubble_cnt_p1 <= bubble_cnt_p1 + CNT_ONE;
      if (cmd_p0 == CMD_FLUSH)  flush_cnt_p1  <= flush_cnt_p1 + CNT_ONE;
    end
  end

  assign bubble_cnt = bubble_cnt_p1;
  assign flush_cnt  = flush_cnt_p1;
`endif

  assign out_valid   = valid_p1;
  assign out_payload = payload_p1;
  assign out_pc      = pc_p1;
  assign out_bd      = bd_p1;
  assign out_exc     = exc_p1;
  assign hold_cycles = hold_p1;

endmodule
